regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between the ALU writeback (A)
//  and the load/memory writeback (B) using a valid/ready handshake.
//  Tracks in-flight destination registers in a 32-entry pending scoreboard and
//  flags read-after-write hazards for decode. Sits between the EX/MEM
//  writeback sources and the register file's regWen/writeReg/writeData inputs.
// PARAMETERS
//  XLEN        32  data width of the write port
//  STARVE_MAX  3   consecutive cycles B may be refused before B gets priority
// PORTS
//  Clk        in   1     clock
//  Rst        in   1     reset, synchronous, active-low
//  a_valid    in   1     ALU writeback request
//  a_rd       in   5     ALU destination register
//  a_data     in   XLEN  ALU result
//  a_ready    out  1     ALU request accepted this cycle
//  b_valid    in   1     load writeback request
//  b_rd       in   5     load destination register
//  b_data     in   XLEN  load data
//  b_ready    out  1     load request accepted this cycle
//  iss_valid  in   1     an instruction with a destination issues this cycle
//  iss_rd     in   5     destination of the issuing instruction
//  rs1, rs2   in   5     source registers of the instruction in decode
//  stall      out  1     RAW hazard: rs1 or rs2 is pending
//  pend       out  32    pending-write scoreboard
//  regWen     out  1     register file write enable (registered)
//  writeReg   out  5     register file write address (registered)
//  writeData  out  XLEN  register file write data (registered)
// BEHAVIOUR
//  Reset (Rst==0 at posedge Clk):
//   - regWen=0, writeReg=0, writeData=0, pend=0.
//   - FSM state=PRI_A, starve count=0.
//   - a_ready=b_ready=0 while Rst==0.
//   - Requests presented during reset are dropped.
//   - No write is issued in the cycle after reset.
//  Handshake:
//   - Transfer occurs when x_valid && x_ready.
//   - a_ready/b_ready are combinational from state and valids.
//   - At most one is high per cycle.
//   - The source holds rd and data stable until accepted.
//  FSM:
//   - PRI_A: grant A if a_valid, else grant B if b_valid.
//   - PRI_B: grant B if b_valid, else grant A if a_valid.
//   - Starve count (2 bits sufficient at default): increments each cycle
//     b_valid && !b_ready (saturating). Clears on a B transfer.
//   - PRI_A -> PRI_B when the count reaches STARVE_MAX.
//   - PRI_B -> PRI_A on a B transfer.
//   - PRI_B also -> PRI_A when b_valid drops; the count then clears.
//  Latency: a transfer in cycle N drives regWen=1 with that rd/data in cycle
//   N+1 for exactly one cycle. Otherwise regWen=0; writeReg/writeData hold.
//  x0: a transfer with rd==0 is accepted (ready=1), but regWen stays 0.
//  Scoreboard:
//   - iss_valid && iss_rd!=0 sets pend[iss_rd] at the posedge.
//   - A cycle with regWen=1 clears pend[writeReg] at the posedge.
//   - Set and clear of the same index in the same cycle: set wins.
//   - pend[0] is always 0.
//   - Writes to non-pending registers are legal and leave pend unchanged.
//  stall = (rs1!=0 && pend[rs1]) || (rs2!=0 && pend[rs2]).
//   - Combinational from the registered pend.
//   - The cycle regWen is high still reports stall. The register file writes
//     combinationally, so decode may read the new value in the following cycle.
//  No back-pressure from the register file: one write per cycle, always taken.
// TESTING
//  1. Reset, then a_valid,a_rd=5,a_data=0x11 for 1 cycle -> a_ready=1;
//     next cycle regWen=1, writeReg=5, writeData=0x11; then regWen=0.
//  2. a_valid and b_valid held every cycle (a_rd=1, b_rd=2) -> grants A,A,A,B,
//     A,A,A,B... with STARVE_MAX=3; never two readys high together.
//  3. b_valid,b_rd=0,b_data=0xFF -> b_ready=1; regWen stays 0; pend unchanged.
//  4. iss_valid,iss_rd=7, then rs1=7 -> stall=1; a write of rd=7 commits
//     -> pend[7]=0 and stall=0 one cycle after regWen.
//  5. Same cycle iss_rd=9 and regWen commits writeReg=9 -> pend[9] remains 1.
//  6. Rst=0 asserted the cycle after a transfer -> regWen=0 next cycle,
//     pend=0, state PRI_A, readys low during reset.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B) writeback,
// with B starvation protection and a pending-destination scoreboard for RAW stalls.
module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            a_valid,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    output logic            a_ready,
    input  logic            b_valid,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            b_ready,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            stall,
    output logic [31:0]     pend,
    output logic            regWen,
    output logic [4:0]      writeReg,
    output logic [XLEN-1:0] writeData
);

    localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [0:0] {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              reg_wen_q, reg_wen_d;
    logic [4:0]        write_reg_q, write_reg_d;
    logic [XLEN-1:0]   write_data_q, write_data_d;
    logic [31:0]       pend_q, pend_d;
    logic              a_xfer, b_xfer;
    logic [4:0]        wr_rd;
    logic [XLEN-1:0]   wr_data;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (cnt >= STARVE_LIM) ? STARVE_LIM : cnt + CNT_W'(1);
    endfunction

    // Grant selection and priority FSM
    always_comb begin
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        state_d  = state_q;
        starve_d = starve_q;
        if (Rst) begin
            case (state_q)
                PRI_A: begin
                    a_ready = a_valid;
                    b_ready = b_valid && !a_valid;
                end
                default: begin
                    b_ready = b_valid;
                    a_ready = a_valid && !b_valid;
                end
            endcase
        end
        a_xfer = a_valid && a_ready;
        b_xfer = b_valid && b_ready;

        if (b_xfer) begin
            starve_d = '0;
        end else if (b_valid && !b_ready) begin
            starve_d = sat_inc(starve_q);
        end

        case (state_q)
            PRI_A: begin
                if (starve_d == STARVE_LIM) begin
                    state_d = PRI_B;
                end
            end
            default: begin
                if (b_xfer) begin
                    state_d = PRI_A;
                end else if (!b_valid) begin
                    state_d  = PRI_A;
                    starve_d = '0;
                end
            end
        endcase
    end

    // Writeback stage: x0 transfers are accepted but never written
    always_comb begin
        wr_rd        = a_xfer ? a_rd : b_rd;
        wr_data      = a_xfer ? a_data : b_data;
        reg_wen_d    = (a_xfer || b_xfer) && (wr_rd != 5'd0);
        write_reg_d  = reg_wen_d ? wr_rd : write_reg_q;
        write_data_d = reg_wen_d ? wr_data : write_data_q;
    end

    // Scoreboard: a new issue to the same register outranks the retiring write
    always_comb begin
        pend_d = pend_q;
        if (reg_wen_q) begin
            pend_d[write_reg_q] = 1'b0;
        end
        if (iss_valid && (iss_rd != 5'd0)) begin
            pend_d[iss_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q      <= PRI_A;
            starve_q     <= '0;
            reg_wen_q    <= 1'b0;
            write_reg_q  <= 5'd0;
            write_data_q <= '0;
            pend_q       <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            reg_wen_q    <= reg_wen_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            pend_q       <= pend_d;
        end
    end

    assign stall     = ((rs1 != 5'd0) && pend_q[rs1]) || ((rs2 != 5'd0) && pend_q[rs2]);
    assign pend      = pend_q;
    assign regWen    = reg_wen_q;
    assign writeReg  = write_reg_q;
    assign writeData = write_data_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter: one table row per clock
// cycle, plus a hand-written sequence for the PRI_B-abandon corner case.
module tb_regfile_wb_arbiter;

    logic        Clk;
    logic        Rst;
    logic        a_valid, b_valid, a_ready, b_ready;
    logic [4:0]  a_rd, b_rd, iss_rd, rs1, rs2, writeReg;
    logic [31:0] a_data, b_data, writeData, pend;
    logic        iss_valid, stall, regWen;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wb_arbiter #(.XLEN(32), .STARVE_MAX(3)) dut (
        .Clk(Clk), .Rst(Rst),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
        .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
        .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
        .stall(stall), .pend(pend),
        .regWen(regWen), .writeReg(writeReg), .writeData(writeData)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic        rst_n;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  brd;
        logic [31:0] bd;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_ar;
        logic        e_br;
        logic        e_stall;
        logic        e_wen;
        logic        chk_wd;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
        logic [31:0] e_pend;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        Rst       = v.rst_n;
        a_valid   = v.av;  a_rd = v.ard; a_data = v.ad;
        b_valid   = v.bv;  b_rd = v.brd; b_data = v.bd;
        iss_valid = v.iv;  iss_rd = v.ird;
        rs1       = v.r1;  rs2 = v.r2;
        #2;
        chk($sformatf("v%0d a_ready", idx), {31'd0, a_ready}, {31'd0, v.e_ar});
        chk($sformatf("v%0d b_ready", idx), {31'd0, b_ready}, {31'd0, v.e_br});
        chk($sformatf("v%0d ready_mutex", idx), {31'd0, a_ready && b_ready}, 32'd0);
        chk($sformatf("v%0d stall", idx), {31'd0, stall}, {31'd0, v.e_stall});
        chk($sformatf("v%0d regWen", idx), {31'd0, regWen}, {31'd0, v.e_wen});
        chk($sformatf("v%0d pend", idx), pend, v.e_pend);
        if (v.chk_wd) begin
            chk($sformatf("v%0d writeReg", idx), {27'd0, writeReg}, {27'd0, v.e_wreg});
            chk($sformatf("v%0d writeData", idx), writeData, v.e_wdata);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic step_ab(input logic av, input logic bv, input logic ear,
                           input logic ebr, input string nm);
        Rst = 1'b1;
        a_valid = av; a_rd = 5'd1; a_data = 32'hA1;
        b_valid = bv; b_rd = 5'd2; b_data = 32'hB2;
        iss_valid = 1'b0; iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        #2;
        chk({nm, " a_ready"}, {31'd0, a_ready}, {31'd0, ear});
        chk({nm, " b_ready"}, {31'd0, b_ready}, {31'd0, ebr});
        @(posedge Clk);
        #1;
    endtask

    initial begin
        //         rst av ard    ad      bv brd   bd      iv ird   rs1   rs2    ar br st wen cw wreg  wdata   pend
        vecs[0]  = '{0, 1, 5'd5, 32'h11, 1, 5'd2, 32'hB2, 0, 5'd0, 5'd0, 5'd0,  0, 0, 0, 0, 1, 5'd0, 32'h0,  32'h0};
        vecs[1]  = '{1, 1, 5'd5, 32'h11, 0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 5'd0,  1, 0, 0, 0, 1, 5'd0, 32'h0,  32'h0};
        vecs[2]  = '{1, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 5'd0,  0, 0, 0, 1, 1, 5'd5, 32'h11, 32'h0};
        vecs[3]  = '{1, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 5'd0,  0, 0, 0, 0, 1, 5'd5, 32'h11, 32'h0};
        vecs[4]  = '{1, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 0, 5'd0, 5'd0, 5'd0,  1, 0, 0, 0, 1, 5'd5, 32'h11, 32'h0};
        vecs[5]  = '{1, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 0, 5'd0, 5'd0, 5'd0,  1, 0, 0, 1, 1, 5'd1, 32'hA1, 32'h0};
        vecs[6]  = '{1, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 0, 5'd0, 5'd0, 5'd0,  1, 0, 0, 1, 1, 5'd1, 32'hA1, 32'h0};
        vecs[7]  = '{1, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 1, 1, 5'd1, 32'hA1, 32'h0};
        vecs[8]  = '{1, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 0, 5'd0, 5'd0, 5'd0,  1, 0, 0, 1, 1, 5'd2, 32'hB2, 32'h0};
        vecs[9]  = '{1, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 0, 5'd0, 5'd0, 5'd0,  1, 0, 0, 1, 1, 5'd1, 32'hA1, 32'h0};
        vecs[10] = '{1, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 0, 5'd0, 5'd0, 5'd0,  1, 0, 0, 1, 1, 5'd1, 32'hA1, 32'h0};
        vecs[11] = '{1, 1, 5'd1, 32'hA1, 1, 5'd2, 32'hB2, 0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 1, 1, 5'd1, 32'hA1, 32'h0};
        vecs[12] = '{1, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 5'd0,  0, 0, 0, 1, 1, 5'd2, 32'hB2, 32'h0};
        vecs[13] = '{1, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 5'd0,  0, 0, 0, 0, 1, 5'd2, 32'hB2, 32'h0};
        vecs[14] = '{1, 0, 5'd0, 32'h0,  1, 5'd0, 32'hFF, 0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 1, 5'd2, 32'hB2, 32'h0};
        vecs[15] = '{1, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 5'd0,  0, 0, 0, 0, 1, 5'd2, 32'hB2, 32'h0};
        vecs[16] = '{1, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1, 5'd7, 5'd0, 5'd0,  0, 0, 0, 0, 1, 5'd2, 32'hB2, 32'h0};
        vecs[17] = '{1, 1, 5'd7, 32'h77, 0, 5'd0, 32'h0,  0, 5'd0, 5'd7, 5'd0,  1, 0, 1, 0, 1, 5'd2, 32'hB2, 32'h80};
        vecs[18] = '{1, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 5'd0, 5'd7, 5'd0,  0, 0, 1, 1, 1, 5'd7, 32'h77, 32'h80};
        vecs[19] = '{1, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 5'd0, 5'd7, 5'd0,  0, 0, 0, 0, 1, 5'd7, 32'h77, 32'h0};
        vecs[20] = '{1, 1, 5'd9, 32'h99, 0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 5'd0,  1, 0, 0, 0, 1, 5'd7, 32'h77, 32'h0};
        vecs[21] = '{1, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1, 5'd9, 5'd0, 5'd9,  0, 0, 0, 1, 1, 5'd9, 32'h99, 32'h0};
        vecs[22] = '{1, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  1, 5'd0, 5'd0, 5'd9,  0, 0, 1, 0, 1, 5'd9, 32'h99, 32'h200};
        vecs[23] = '{1, 1, 5'd3, 32'h33, 0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 5'd9,  1, 0, 1, 0, 1, 5'd9, 32'h99, 32'h200};
        vecs[24] = '{0, 1, 5'd3, 32'h33, 1, 5'd2, 32'hB2, 0, 5'd0, 5'd0, 5'd9,  0, 0, 1, 1, 1, 5'd3, 32'h33, 32'h200};
        vecs[25] = '{1, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 5'd9,  0, 0, 0, 0, 1, 5'd0, 32'h0,  32'h0};
        vecs[26] = '{1, 0, 5'd0, 32'h0,  0, 5'd0, 32'h0,  0, 5'd0, 5'd0, 5'd0,  0, 0, 0, 0, 1, 5'd0, 32'h0,  32'h0};

        Rst = 1'b0;
        a_valid = 1'b0; a_rd = 5'd0; a_data = 32'h0;
        b_valid = 1'b0; b_rd = 5'd0; b_data = 32'h0;
        iss_valid = 1'b0; iss_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
        @(posedge Clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i], i);
        end

        // B abandons its priority turn: count must clear, so A,A,A,B restarts
        step_ab(1, 1, 1, 0, "s0");
        step_ab(1, 1, 1, 0, "s1");
        step_ab(1, 1, 1, 0, "s2");
        step_ab(1, 0, 1, 0, "s3_bdrop");
        step_ab(1, 1, 1, 0, "s4");
        step_ab(1, 1, 1, 0, "s5");
        step_ab(1, 1, 1, 0, "s6");
        step_ab(1, 1, 0, 1, "s7");
        step_ab(1, 1, 1, 0, "s8");
        step_ab(0, 0, 0, 0, "s9");

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
